bus_txn_monitor: RTL

- Synthesisable, multi-channel successor to the single-channel bus assertion checker.
- Per channel, enforces the same transfer rules as runtime RTL:
  - valid and ready held together for exactly BURST_LEN cycles;
  - ready within READY_MAX cycles of request;
  - done within DONE_MAX cycles of request.
- Reports violations as pulses plus sticky flags and counts clean transactions.
- Sits beside the bus in sim and FPGA builds, where SVA is unavailable.

---
 rtl/bus_mon_pkg.sv | 37 +++
 rtl/bus_mon_channel.sv | 159 +++++++++++++++
 rtl/bus_txn_monitor.sv | 65 ++++++
 3 files changed

// File: rtl/bus_mon_pkg.sv
// Shared types and helpers for the multi-channel bus transaction monitor.
// Provides the channel FSM state encoding, the error pulse bundle and the
// width helpers used to size per-channel timers and beat counters.
package bus_mon_pkg;

  localparam logic [2:0] IDLE_ENC      = 3'd0;
  localparam logic [2:0] WAIT_RDY_ENC  = 3'd1;
  localparam logic [2:0] BURST_ENC     = 3'd2;
  localparam logic [2:0] CHECK_END_ENC = 3'd3;
  localparam logic [2:0] WAIT_DONE_ENC = 3'd4;
  localparam logic [2:0] DRAIN_ENC     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = IDLE_ENC,
    ST_WAIT_RDY  = WAIT_RDY_ENC,
    ST_BURST     = BURST_ENC,
    ST_CHECK_END = CHECK_END_ENC,
    ST_WAIT_DONE = WAIT_DONE_ENC,
    ST_DRAIN     = DRAIN_ENC
  } state_e;

  typedef struct packed {
    logic ready;
    logic burst;
    logic done;
  } err_t;

  // Timer must be able to hold DONE_MAX+1 so it can saturate past the window.
  function automatic int timer_w(input int done_max);
    return $clog2(done_max + 2);
  endfunction

  function automatic int beat_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/bus_mon_channel.sv
// One channel of the bus transaction monitor: transfer FSM, request timer,
// beat counter, done tracking, sticky error flag and clean-transfer counter.
// Ports: clk_i/rst_i (async active-high), clear_i (sync clear of sticky and
// count), valid_i/ready_i/done_i (bus observation), busy_o (FSM not IDLE),
// err_o (registered 1-cycle error pulses), err_sticky_o, xfer_count_o.
//
// state     | meaning
// IDLE      | no request outstanding, waiting for valid
// WAIT_RDY  | request seen, waiting for first valid&ready beat
// BURST     | counting consecutive valid&ready beats
// CHECK_END | first cycle after the last beat, overrun check
// WAIT_DONE | burst finished, waiting for done strobe
// DRAIN     | error reported, waiting for valid to drop
module bus_mon_channel
  import bus_mon_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int READY_MAX = 4,
  parameter int DONE_MAX  = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic             done_i,
  output logic             busy_o,
  output err_t             err_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] xfer_count_o
);

  localparam int TW = timer_w(DONE_MAX);
  localparam int BW = beat_w(BURST_LEN);
  localparam logic [TW-1:0] T_READY = TW'(READY_MAX);
  localparam logic [TW-1:0] T_DONE  = TW'(DONE_MAX);
  localparam logic [TW-1:0] T_SAT   = TW'(DONE_MAX + 1);
  localparam logic [BW-1:0] B_LAST  = BW'(BURST_LEN);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              done_seen_q, done_seen_d;
  err_t              err_q, err_d;
  logic              sticky_q;
  logic [CNT_W-1:0]  count_q;
  logic              complete;
  logic              active;
  logic              hs;
  logic              done_hit;
  logic              done_late;

  assign active    = (state_q != ST_IDLE) && (state_q != ST_DRAIN);
  assign hs        = valid_i & ready_i;
  // The timer is already >= 1 in every active state, so done at T0 never lands here.
  assign done_hit  = done_i && (timer_q >= TW'(1)) && (timer_q <= T_DONE);
  assign done_late = !done_seen_q && !done_hit && (timer_q >= T_DONE);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    beat_d      = beat_q;
    done_seen_d = done_seen_q;
    err_d       = '0;
    complete    = 1'b0;

    if (active) begin
      if (timer_q != T_SAT) timer_d = timer_q + TW'(1);
      done_seen_d = done_seen_q | done_hit;
      err_d.done  = done_late;
    end

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d     = ST_WAIT_RDY;
          timer_d     = TW'(1);
          beat_d      = '0;
          done_seen_d = 1'b0;
        end
      end
      ST_WAIT_RDY: begin
        if (hs) begin
          beat_d  = BW'(1);
          state_d = (BURST_LEN == 1) ? ST_CHECK_END : ST_BURST;
        end else begin
          err_d.burst = !valid_i;
          err_d.ready = (timer_q == T_READY);
        end
      end
      ST_BURST: begin
        if (hs) begin
          beat_d = beat_q + BW'(1);
          if (beat_q + BW'(1) == B_LAST) state_d = ST_CHECK_END;
        end else begin
          err_d.burst = 1'b1;
        end
      end
      ST_CHECK_END: begin
        if (hs) begin
          err_d.burst = 1'b1;
        end else if (done_seen_q || done_hit) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done_hit) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_d != '0) state_d = ST_DRAIN;
    if (state_d == ST_IDLE) begin
      timer_d = '0;
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      beat_q      <= '0;
      done_seen_q <= 1'b0;
      err_q       <= '0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      beat_q      <= beat_d;
      done_seen_q <= done_seen_d;
      err_q       <= err_d;
      // A new error outranks a coincident clear.
      sticky_q    <= (sticky_q & ~clear_i) | (err_d != '0);
      if (clear_i) begin
        count_q <= complete ? CNT_W'(1) : '0;
      end else if (complete && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
  assign xfer_count_o = count_q;

endmodule

// File: rtl/bus_txn_monitor.sv
// Multi-channel bus transaction monitor. Each channel independently checks
// burst length, ready latency and done latency and counts clean transfers.
// Ports: clk/rst (async active-high), clear (sync clear of sticky/counts),
// valid/ready/done per channel in; busy, err_ready/err_burst/err_done
// pulses, err_sticky per channel, err_any, and packed xfer_count out.
module bus_txn_monitor
  import bus_mon_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = 4,
  parameter int READY_MAX = 4,
  parameter int DONE_MAX  = 8,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       valid,
  input  logic [NUM_CH-1:0]       ready,
  input  logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       err_ready,
  output logic [NUM_CH-1:0]       err_burst,
  output logic [NUM_CH-1:0]       err_done,
  output logic [NUM_CH-1:0]       err_sticky,
  output logic                    err_any,
  output logic [NUM_CH*CNT_W-1:0] xfer_count
);

  generate
    if (NUM_CH < 1 || CNT_W < 1 || BURST_LEN < 1 || READY_MAX < 1 ||
        DONE_MAX < READY_MAX + BURST_LEN - 1) begin : g_bad_params
      $error("bus_txn_monitor: illegal parameter combination");
    end
  endgenerate

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    err_t err_w;

    bus_mon_channel #(
      .BURST_LEN(BURST_LEN),
      .READY_MAX(READY_MAX),
      .DONE_MAX (DONE_MAX),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (clear),
      .valid_i     (valid[i]),
      .ready_i     (ready[i]),
      .done_i      (done[i]),
      .busy_o      (busy[i]),
      .err_o       (err_w),
      .err_sticky_o(err_sticky[i]),
      .xfer_count_o(xfer_count[i*CNT_W +: CNT_W])
    );

    assign err_ready[i] = err_w.ready;
    assign err_burst[i] = err_w.burst;
    assign err_done[i]  = err_w.done;
  end

  assign err_any = |err_sticky;

endmodule
